sequence_detector_overlap: RTL and testbench



---
 rtl/sequence_detector_overlap.sv | 73 +++++++
 tb/tb_sequence_detector_overlap.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sequence_detector_overlap.sv
// sequence_detector_overlap
//   Moore FSM that flags every occurrence of the serial pattern 0110 on X,
//   with overlap (the trailing 0 of one match is the leading 0 of the next).
//   Optional feature macro: SEQ_DET_COUNT_EN adds an 8-bit saturating
//   detection counter on port det_count.
module sequence_detector_overlap (
  input  logic       clock,
  input  logic       reset,
  input  logic       X,
  output logic       Y
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [7:0] det_count
`endif
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // no useful prefix
    S1 = 3'd1,  // seen "0"
    S2 = 3'd2,  // seen "01"
    S3 = 3'd3,  // seen "011"
    S4 = 3'd4   // seen "0110" (detect)
  } state_t;

  state_t state, state_nxt;

  // State register; reset wins over X on the same edge.
  always_ff @(posedge clock) begin
    if (reset) state <= S0;
    else       state <= state_nxt;
  end

  // Next-state logic; unknown X or unused encodings fall back to idle.
  always_comb begin
    state_nxt = S0;
    if (X === 1'b0) begin
      case (state)
        S0:      state_nxt = S1;
        S1:      state_nxt = S1;
        S2:      state_nxt = S1;
        S3:      state_nxt = S4;
        S4:      state_nxt = S1;
        default: state_nxt = S0;
      endcase
    end else if (X === 1'b1) begin
      case (state)
        S0:      state_nxt = S0;
        S1:      state_nxt = S2;
        S2:      state_nxt = S3;
        S3:      state_nxt = S0;
        S4:      state_nxt = S2;  // overlap: trailing 0 + this 1 = "01"
        default: state_nxt = S0;
      endcase
    end
  end

  // Moore output: decoded from the state register only, no path from X.
  always_comb begin
    Y = (state == S4);
  end

`ifdef SEQ_DET_COUNT_EN
  // Saturating detection counter; bumps on the edge that enters S4 so it
  // moves in the same cycle Y rises.
  always_ff @(posedge clock) begin
    if (reset)
      det_count <= 8'd0;
    else if ((state_nxt == S4) && (det_count != 8'hFF))
      det_count <= det_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sequence_detector_overlap.sv
// tb_sequence_detector_overlap
//   Directed plus randomized stimulus checked against a bit-history model:
//   a detection is expected whenever the last four bits received since reset
//   read 0110. Build with +define+SEQ_DET_COUNT_EN to also check det_count.
module tb_sequence_detector_overlap;

  logic       clock;
  logic       reset;
  logic       X;
  logic       Y;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] det_count;
`endif

  sequence_detector_overlap dut (
    .clock     (clock),
    .reset     (reset),
    .X         (X),
    .Y         (Y)
`ifdef SEQ_DET_COUNT_EN
    ,
    .det_count (det_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  bit hist[$];     // bits received since the last reset, newest at back
  bit exp_y;
  int exp_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one edge with given reset / X, update the model, check outputs.
  task automatic step(input bit r, input bit x, input string tag);
    int n;
    reset = r;
    X     = x;
    @(posedge clock);
    if (r) begin
      hist.delete();
      exp_y   = 1'b0;
      exp_cnt = 0;
    end else begin
      hist.push_back(x);
      if (hist.size() > 4) void'(hist.pop_front());
      n = hist.size();
      exp_y = (n == 4) && !hist[0] && hist[1] && hist[2] && !hist[3];
      if (exp_y && exp_cnt < 255) exp_cnt++;
    end
    #1;
    chk(tag, int'(Y), int'(exp_y));
`ifdef SEQ_DET_COUNT_EN
    chk({tag, "_cnt"}, int'(det_count), exp_cnt);
`endif
    // Y must not follow X without a clock edge
    X = ~x;
    #1;
    chk({tag, "_comb"}, int'(Y), int'(exp_y));
  endtask

  task automatic drive(input string bits, input string tag);
    for (int i = 0; i < bits.len(); i++)
      step(1'b0, bits[i] == "1", tag);
  endtask

  int pulses;

  initial begin
    reset = 1'b1;
    X     = 1'b1;
    exp_y = 1'b0;
    exp_cnt = 0;

    // reset held for two edges with X=1
    step(1'b1, 1'b1, "reset0");
    step(1'b1, 1'b1, "reset1");

    // basic detect
    drive("00110", "basic");
    drive("0", "basic_after");
    chk("basic_low_after", int'(Y), 0);

    // overlap stream: four pulses expected
    step(1'b1, 1'b0, "rst_ov");
    pulses = 0;
    begin
      string s;
      s = "0011011001100110";
      for (int i = 0; i < s.len(); i++) begin
        step(1'b0, s[i] == "1", "overlap");
        if (Y) pulses++;
      end
    end
    chk("overlap_pulses", pulses, 4);
`ifdef SEQ_DET_COUNT_EN
    chk("overlap_count", int'(det_count), 4);
`endif

    // non-match
    step(1'b1, 1'b0, "rst_nm");
    drive("0111010", "nomatch");

    // reset mid-pattern, then complete a fresh match
    step(1'b1, 1'b0, "rst_mid0");
    drive("011", "mid_pre");
    step(1'b1, 1'b0, "mid_reset");
    drive("0", "mid_post");
    drive("110", "mid_match");
    chk("mid_match_y", int'(Y), 1);

`ifdef SEQ_DET_COUNT_EN
    // saturation
    step(1'b1, 1'b0, "rst_sat");
    drive("0110", "sat");
    for (int k = 0; k < 259; k++) drive("110", "sat");
    chk("sat_hold", int'(det_count), 255);
`endif

    // randomized stream with occasional resets
    step(1'b1, 1'b0, "rst_rnd");
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit x;
      r = ($urandom_range(0, 63) == 0);
      // bias toward patterns that actually match
      x = ($urandom_range(0, 2) != 0) ? bit'(i % 3 != 0) : bit'($urandom_range(0, 1));
      step(r, x, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global timeout guard
  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
